// File: rtl/fx_chain_scheduler.sv
// fx_chain_scheduler: runs each sample through the enabled effect slots in index order and owns the smart_ram port.
// Define FX_TIMEOUT_EN to add a per-effect watchdog that bypasses a stuck slot and flags it on fx_timeout.
module fx_chain_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_FX     = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [DATA_WIDTH-1:0]      sample_in,
    input  logic [NUM_FX-1:0]          fx_enable,
    input  logic                       sram_hold,
    output logic [DATA_WIDTH-1:0]      sample_out,
    output logic                       sample_out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [NUM_FX-1:0]          fx_cs,
    output logic [NUM_FX-1:0]          fx_my_turn,
    output logic [DATA_WIDTH-1:0]      fx_data_in,
    input  logic [NUM_FX-1:0]          fx_done,
    input  logic [NUM_FX-1:0]          fx_available,
    input  logic [NUM_FX*DATA_WIDTH-1:0] fx_data_out,
    input  logic [NUM_FX-1:0]          fx_sram_rd,
    input  logic [NUM_FX-1:0]          fx_sram_wr,
    input  logic [NUM_FX*ADDR_WIDTH-1:0] fx_sram_offset,
    input  logic [NUM_FX*DATA_WIDTH-1:0] fx_sram_data,
    output logic [NUM_FX-1:0]          fx_sram_read_finish,
    output logic [NUM_FX-1:0]          fx_sram_write_finish,
    output logic [DATA_WIDTH-1:0]      fx_sram_rdata,
    output logic                       sram_rd,
    output logic                       sram_wr,
    output logic [ADDR_WIDTH-1:0]      sram_offset,
    output logic [DATA_WIDTH-1:0]      sram_data_out,
    input  logic [DATA_WIDTH-1:0]      sram_data_in,
    input  logic                       sram_read_finish,
    input  logic                       sram_write_finish
`ifdef FX_TIMEOUT_EN
    ,
    output logic [NUM_FX-1:0]          fx_timeout
`endif
);
    localparam int IW = $clog2(NUM_FX) + 1;
    typedef enum logic [1:0] {IDLE, SELECT, WAIT, OUTPUT} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] acc, dout_cur, dat_cur;
    logic [ADDR_WIDTH-1:0] off_cur;
    logic [IW-1:0] idx, cur, sel;
    logic [NUM_FX-1:0] mask;
    logic found, avail_sel, done_cur, rd_cur, wr_cur, grant, expire;
`ifdef FX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
    assign expire = wd == TW'(TIMEOUT - 1);
`else
    assign expire = 1'b0;
`endif
    // sel scans upward from idx; the cur slot's signals are picked out for the WAIT mux
    always_comb begin
        found = 1'b0;
        sel = '0;
        avail_sel = 1'b0;
        for (int i = NUM_FX - 1; i >= 0; i--)
            if (mask[i] && IW'(i) >= idx) begin
                found = 1'b1;
                sel = IW'(i);
                avail_sel = fx_available[i];
            end
        done_cur = 1'b0;
        dout_cur = '0;
        rd_cur = 1'b0;
        wr_cur = 1'b0;
        off_cur = '0;
        dat_cur = '0;
        for (int i = 0; i < NUM_FX; i++)
            if (IW'(i) == cur) begin
                done_cur = fx_done[i];
                dout_cur = fx_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                rd_cur = fx_sram_rd[i];
                wr_cur = fx_sram_wr[i];
                off_cur = fx_sram_offset[i*ADDR_WIDTH +: ADDR_WIDTH];
                dat_cur = fx_sram_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
    end
    assign grant = state == SELECT && found && !sram_hold && avail_sel;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sample_valid ? SELECT : IDLE;
            SELECT:  state_nx = !found ? OUTPUT : grant ? WAIT : SELECT;
            WAIT:    state_nx = (done_cur || expire) ? SELECT : WAIT;
            OUTPUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            idx <= '0;
            cur <= '0;
            mask <= '0;
            sample_out <= '0;
            sample_out_valid <= 1'b0;
            overrun <= 1'b0;
            fx_my_turn <= '0;
`ifdef FX_TIMEOUT_EN
            wd <= '0;
            fx_timeout <= '0;
`endif
        end else begin
            sample_out_valid <= state == OUTPUT;
            overrun <= sample_valid && state != IDLE;
            fx_my_turn <= grant ? NUM_FX'(1) << sel : '0;
            if (state == IDLE && sample_valid) begin
                acc <= sample_in;
                mask <= fx_enable;
                idx <= '0;
            end
            if (grant) cur <= sel;
            if (state == WAIT && (done_cur || expire)) idx <= cur + 1'b1;
            if (state == WAIT && done_cur) acc <= dout_cur;
            if (state == OUTPUT) sample_out <= acc;
`ifdef FX_TIMEOUT_EN
            wd <= (state == WAIT) ? wd + 1'b1 : '0;
            if (state == WAIT && !done_cur && expire) fx_timeout <= fx_timeout | (NUM_FX'(1) << cur);
`endif
        end
    end
    assign busy = state != IDLE;
    assign fx_cs = mask;
    assign fx_data_in = acc;
    assign fx_sram_rdata = sram_data_in;
    assign sram_rd = state == WAIT && rd_cur;
    assign sram_wr = state == WAIT && wr_cur;
    assign sram_offset = off_cur;
    assign sram_data_out = dat_cur;
    assign fx_sram_read_finish = (state == WAIT && sram_read_finish) ? NUM_FX'(1) << cur : '0;
    assign fx_sram_write_finish = (state == WAIT && sram_write_finish) ? NUM_FX'(1) << cur : '0;
endmodule

// File: tb/tb_fx_chain_scheduler.sv
// tb_fx_chain_scheduler: vector table, directed corner sequences and randomized chains against a sum-of-effects model.
module tb_fx_chain_scheduler;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NF = 3;

    logic clk = 0;
    logic rst = 0;
    logic sample_valid = 0;
    logic [DW-1:0] sample_in = '0;
    logic [NF-1:0] fx_enable = '0;
    logic sram_hold = 0;
    logic [DW-1:0] sample_out, fx_data_in, fx_sram_rdata, sram_data_out;
    logic sample_out_valid, busy, overrun, sram_rd, sram_wr;
    logic [NF-1:0] fx_cs, fx_my_turn, fx_done, fx_available, fx_sram_read_finish, fx_sram_write_finish;
    logic [NF-1:0] fx_sram_rd = '0, fx_sram_wr = '0;
    logic [NF*DW-1:0] fx_data_out;
    logic [NF*DW-1:0] fx_sram_data = '0;
    logic [NF*AW-1:0] fx_sram_offset = '0;
    logic [AW-1:0] sram_offset;
    logic [DW-1:0] sram_data_in = '0;
    logic sram_read_finish = 0, sram_write_finish = 0;
`ifdef FX_TIMEOUT_EN
    logic [NF-1:0] fx_timeout;
`endif

    fx_chain_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FX(NF), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .fx_enable(fx_enable), .sram_hold(sram_hold), .sample_out(sample_out),
        .sample_out_valid(sample_out_valid), .busy(busy), .overrun(overrun),
        .fx_cs(fx_cs), .fx_my_turn(fx_my_turn), .fx_data_in(fx_data_in),
        .fx_done(fx_done), .fx_available(fx_available), .fx_data_out(fx_data_out),
        .fx_sram_rd(fx_sram_rd), .fx_sram_wr(fx_sram_wr), .fx_sram_offset(fx_sram_offset),
        .fx_sram_data(fx_sram_data), .fx_sram_read_finish(fx_sram_read_finish),
        .fx_sram_write_finish(fx_sram_write_finish), .fx_sram_rdata(fx_sram_rdata),
        .sram_rd(sram_rd), .sram_wr(sram_wr), .sram_offset(sram_offset),
        .sram_data_out(sram_data_out), .sram_data_in(sram_data_in),
        .sram_read_finish(sram_read_finish), .sram_write_finish(sram_write_finish)
`ifdef FX_TIMEOUT_EN
        , .fx_timeout(fx_timeout)
`endif
    );

    always #5 clk = ~clk;

    // effect models: on a grant, capture fx_data_in, wait lat cycles, pulse done with in+add
    logic [DW-1:0] add [NF];
    int lat [NF];
    int m_cnt [NF];
    logic [DW-1:0] m_cap [NF];
    logic [DW-1:0] m_dout [NF];
    logic [NF-1:0] m_busy = '0, m_done = '0;
    logic [NF-1:0] man = '0, man_done = '0;
    logic [DW-1:0] man_dout [NF];
    logic [NF-1:0] avail_en = '1;

    always_comb begin
        fx_data_out = '0;
        for (int i = 0; i < NF; i++) begin
            fx_done[i] = man[i] ? man_done[i] : m_done[i];
            fx_data_out[i*DW +: DW] = man[i] ? man_dout[i] : m_dout[i];
            fx_available[i] = avail_en[i] & ~m_busy[i];
        end
    end

    always @(negedge clk)
        for (int i = 0; i < NF; i++) begin
            if (!rst || man[i]) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end else if (fx_my_turn[i]) begin
                m_busy[i] <= 1'b1;
                m_cnt[i] <= lat[i];
                m_cap[i] <= fx_data_in;
                m_done[i] <= 1'b0;
            end else if (m_busy[i] && m_cnt[i] == 0) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b1;
                m_dout[i] <= m_cap[i] + add[i];
            end else begin
                if (m_busy[i]) m_cnt[i] <= m_cnt[i] - 1;
                m_done[i] <= 1'b0;
            end
        end

    int gq[$];
    logic [DW-1:0] dq[$];
    int vcnt = 0, onehot_bad = 0, sram_bad = 0;
    always @(negedge clk) begin
        if (sample_out_valid) vcnt <= vcnt + 1;
        if (!busy && (sram_rd || sram_wr)) sram_bad <= sram_bad + 1;
        if (fx_my_turn != '0) begin
            if ($countones(fx_my_turn) != 1) onehot_bad <= onehot_bad + 1;
            for (int i = 0; i < NF; i++) if (fx_my_turn[i]) gq.push_back(i);
            dq.push_back(fx_data_in);
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic start(input logic [NF-1:0] en, input logic [DW-1:0] s);
        @(negedge clk);
        fx_enable = en;
        sample_in = s;
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
    endtask

    task automatic wait_out(output logic [DW-1:0] v, output int cyc);
        cyc = 0;
        while (!sample_out_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!sample_out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_out: no sample_out_valid within %0d cycles", cyc);
        end
        v = sample_out;
    endtask

    task automatic wait_turn(input int slot);
        int c = 0;
        while (!fx_my_turn[slot] && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_turn", fx_my_turn[slot], 1);
    endtask

    task automatic run_chk(input string nm, input logic [NF-1:0] en, input logic [DW-1:0] s,
                           input logic [DW-1:0] exp_out);
        logic [DW-1:0] v, got;
        int eg[$];
        logic [DW-1:0] ed[$];
        int cyc;
        bit ok;
        v = s;
        for (int i = 0; i < NF; i++)
            if (en[i]) begin
                eg.push_back(i);
                ed.push_back(v);
                v += add[i];
            end
        gq.delete();
        dq.delete();
        start(en, s);
        wait_out(got, cyc);
        chk({nm, "_out"}, got, exp_out);
        ok = gq.size() == eg.size() && dq.size() == ed.size();
        if (ok) foreach (eg[k]) if (gq[k] != eg[k] || dq[k] !== ed[k]) ok = 0;
        chk({nm, "_chain"}, ok, 1);
    endtask

    typedef struct {
        logic [NF-1:0] en;
        logic [DW-1:0] sin;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tv[6];

    initial begin
        logic [DW-1:0] got, ref_out;
        int cyc, bad, v0;
        tv[0] = '{3'b000, 16'h1234, 16'h1234};
        tv[1] = '{3'b101, 16'h0010, 16'h0012};
        tv[2] = '{3'b111, 16'h00ff, 16'h0102};
        tv[3] = '{3'b010, 16'hffff, 16'h0000};
        tv[4] = '{3'b100, 16'h8000, 16'h8001};
        tv[5] = '{3'b011, 16'h0001, 16'h0003};
        for (int i = 0; i < NF; i++) begin
            add[i] = 1;
            lat[i] = 2;
            man_dout[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", fx_cs, 0);
        chk("rst_turn", fx_my_turn, 0);
        chk("rst_overrun", overrun, 0);
`ifdef FX_TIMEOUT_EN
        chk("rst_timeout", fx_timeout, 0);
`endif
        rst = 1;

        // bypass latency: strobe sampled at edge N, valid visible after edge N+2
        gq.delete();
        start(3'b000, 16'h1234);
        chk("lat_n1", sample_out_valid, 0);
        @(negedge clk);
        chk("lat_n2", sample_out_valid, 0);
        @(negedge clk);
        chk("lat_valid", sample_out_valid, 1);
        chk("lat_out", sample_out, 16'h1234);
        chk("lat_no_turn", gq.size(), 0);
        @(negedge clk);
        chk("lat_valid_1cyc", sample_out_valid, 0);

        foreach (tv[k]) run_chk($sformatf("vec%0d", k), tv[k].en, tv[k].sin, tv[k].exp);
        repeat (4) @(negedge clk);
        chk("out_hold", sample_out, 16'h0003);

        // codec hold blocks the grant until the first cycle after it drops
        sram_hold = 1;
        start(3'b001, 16'h0200);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (fx_my_turn != '0) bad++;
        end
        chk("hold_no_grant", bad, 0);
        chk("hold_busy", busy, 1);
        sram_hold = 0;
        @(negedge clk);
        chk("hold_grant", fx_my_turn, 3'b001);
        wait_out(got, cyc);
        chk("hold_out", got, 16'h0201);

        // sram mux: slot1 active, slot0 also asserting a request that must be ignored
        man[1] = 1;
        start(3'b010, 16'h0300);
        wait_turn(1);
        fx_sram_rd = 3'b011;
        fx_sram_wr = 3'b100;
        fx_sram_offset = {AW'(5), AW'(2048), AW'(7)};
        fx_sram_data = {16'h1111, 16'h5a5a, 16'h2222};
        #1;
        chk("sram_rd", sram_rd, 1);
        chk("sram_wr", sram_wr, 0);
        chk("sram_offset", sram_offset, 2048);
        chk("sram_wdata", sram_data_out, 16'h5a5a);
        sram_read_finish = 1;
        sram_data_in = 16'hbeef;
        #1;
        chk("rfinish_gate", fx_sram_read_finish, 3'b010);
        chk("rdata", fx_sram_rdata, 16'hbeef);
        sram_read_finish = 0;
        sram_write_finish = 1;
        #1;
        chk("wfinish_gate", fx_sram_write_finish, 3'b010);
        @(negedge clk);
        sram_write_finish = 0;
        fx_sram_rd = '0;
        fx_sram_wr = '0;
        man_done[1] = 1;
        man_dout[1] = 16'habcd;
        @(negedge clk);
        man_done[1] = 0;
        wait_out(got, cyc);
        chk("sram_out", got, 16'habcd);
        man[1] = 0;
        @(negedge clk);
        fx_sram_rd = '1;
        sram_read_finish = 1;
        #1;
        chk("idle_rfinish", fx_sram_read_finish, 0);
        chk("idle_sram_rd", sram_rd, 0);
        sram_read_finish = 0;
        fx_sram_rd = '0;

        // overrun while an effect is busy
        lat[0] = 10;
        start(3'b001, 16'h0100);
        wait_turn(0);
        v0 = vcnt;
        @(negedge clk);
        sample_valid = 1;
        sample_in = 16'h7777;
        fx_enable = 3'b111;
        @(negedge clk);
        sample_valid = 0;
        chk("overrun_pulse", overrun, 1);
        chk("overrun_mask", fx_cs, 3'b001);
        @(negedge clk);
        chk("overrun_1cyc", overrun, 0);
        wait_out(got, cyc);
        chk("overrun_out", got, 16'h0101);
        repeat (20) @(negedge clk);
        chk("overrun_one_valid", vcnt - v0, 1);
        lat[0] = 2;

        // asynchronous reset in the middle of WAIT
        man[0] = 1;
        start(3'b001, 16'h0400);
        wait_turn(0);
        fx_sram_rd = 3'b001;
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("arst_out", sample_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cs", fx_cs, 0);
        chk("arst_din", fx_data_in, 0);
        chk("arst_sram_rd", sram_rd, 0);
        chk("arst_turn", fx_my_turn, 0);
        @(negedge clk);
        rst = 1;
        fx_sram_rd = '0;
        man[0] = 0;
        v0 = vcnt;
        repeat (10) @(negedge clk);
        chk("arst_no_valid", vcnt - v0, 0);

`ifdef FX_TIMEOUT_EN
        // slot0 never finishes: bypassed after 16 WAIT cycles, output two cycles later
        man[0] = 1;
        start(3'b001, 16'h0500);
        wait_turn(0);
        cyc = 0;
        while (!sample_out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", cyc, 18);
        chk("to_out", sample_out, 16'h0500);
        chk("to_flag", fx_timeout, 3'b001);
        man[0] = 0;
        run_chk("to_after", 3'b011, 16'h0600, 16'h0602);
        chk("to_sticky", fx_timeout, 3'b001);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [NF-1:0] en;
            logic [DW-1:0] s;
            en = NF'($urandom_range(0, (1 << NF) - 1));
            s = DW'($urandom);
            ref_out = s;
            for (int i = 0; i < NF; i++) begin
                add[i] = DW'($urandom);
                lat[i] = $urandom_range(0, 4);
                if (en[i]) ref_out += add[i];
            end
            run_chk($sformatf("rnd%0d", n), en, s, ref_out);
        end

        chk("turn_onehot", onehot_bad, 0);
        chk("sram_idle_quiet", sram_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
